// File: rtl/spi_resp.sv
// SPI mode-3 responder: oversamples SS_n/SCLK/MOSI in the clk domain, receives a
// 16-bit command and shifts out a host-loaded 16-bit response MSB first.
module spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  input  logic        clr_rdy,
  output logic [15:0] cmd_rcvd,
  output logic        rdy,
  output logic        ovr,
  output logic        frm_err
);

  localparam logic [4:0] LAST_RISE = 5'd16;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

  state_t state, nxt_state;

  logic ss_p0, ss_p1, ss_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1, mosi_p2;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] shift_reg, tx_buf;
  logic        mosi_smpl;
  logic [4:0]  rise_cnt;

  logic ld_shift, shift_en, smpl_en, cnt_clr, cmplt, abort;

  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    return (cnt >= LAST_RISE) ? LAST_RISE : cnt + 5'd1;
  endfunction

  function automatic logic [15:0] shift_in(input logic [15:0] word, input logic bit_in);
    return {word[14:0], bit_in};
  endfunction

  // stage p0/p1: two-flop synchronizers, p2: edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_p0   <= 1'b1;
      ss_p1   <= 1'b1;
      ss_p2   <= 1'b1;
      sclk_p0 <= 1'b1;
      sclk_p1 <= 1'b1;
      sclk_p2 <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      mosi_p2 <= 1'b0;
    end else begin
      ss_p0   <= SS_n;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= MOSI;
      mosi_p1 <= mosi_p0;
      mosi_p2 <= mosi_p1;
    end
  end

  assign ss_fall   =  ss_p2   & ~ss_p1;
  assign ss_rise   = ~ss_p2   &  ss_p1;
  assign sclk_rise = ~sclk_p2 &  sclk_p1;
  assign sclk_fall =  sclk_p2 & ~sclk_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // SS_n rise is tested before any SCLK edge so it always takes precedence
  always_comb begin
    nxt_state = state;
    ld_shift  = 1'b0;
    shift_en  = 1'b0;
    smpl_en   = 1'b0;
    cnt_clr   = 1'b0;
    cmplt     = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          ld_shift  = 1'b1;
          cnt_clr   = 1'b1;
          nxt_state = ARMED;
        end
      end
      ARMED: begin
        if (ss_rise) begin
          nxt_state = IDLE;
        end else if (sclk_rise) begin
          smpl_en   = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (rise_cnt == LAST_RISE) cmplt = 1'b1;
          else                       abort = 1'b1;
          nxt_state = IDLE;
        end else if (sclk_rise) begin
          smpl_en = (rise_cnt < LAST_RISE);
        end else if (sclk_fall) begin
          if (rise_cnt < LAST_RISE) begin
            shift_en = 1'b1;
          end else begin
            cmplt     = 1'b1;
            nxt_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (ss_rise) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf    <= '0;
      shift_reg <= '0;
      mosi_smpl <= 1'b0;
      rise_cnt  <= '0;
      cmd_rcvd  <= '0;
      rdy       <= 1'b0;
      ovr       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      frm_err <= abort;
      if (wrt) tx_buf <= tx_data;
      // a wrt in the load cycle bypasses tx_buf so the new word goes out this frame
      if (ld_shift)      shift_reg <= wrt ? tx_data : tx_buf;
      else if (shift_en) shift_reg <= shift_in(shift_reg, mosi_smpl);
      if (cnt_clr) begin
        rise_cnt <= '0;
      end else if (smpl_en) begin
        mosi_smpl <= mosi_p2;
        rise_cnt  <= sat_inc(rise_cnt);
      end
      // completion beats clr_rdy; overrun only when the old frame was still unread
      if (cmplt) begin
        cmd_rcvd <= shift_in(shift_reg, mosi_smpl);
        rdy      <= 1'b1;
        if (rdy && !clr_rdy) ovr <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

  assign MISO = SS_n ? 1'bz : shift_reg[15];

endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: a mode-3 master model drives frames; expected command and
// response words are queued at frame start and compared once the frame settles.
module tb_spi_resp;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  wire         miso_w;
  logic        wrt;
  logic [15:0] tx_data;
  logic        clr_rdy;
  logic [15:0] cmd_rcvd;
  logic        rdy, ovr, frm_err;

  pullup (miso_w);

  spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (miso_w),
    .wrt      (wrt),
    .tx_data  (tx_data),
    .clr_rdy  (clr_rdy),
    .cmd_rcvd (cmd_rcvd),
    .rdy      (rdy),
    .ovr      (ovr),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frm_cnt = 0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_miso_q[$];
  logic [15:0] model_tx_buf;
  logic [15:0] rd;

  bit          opt_trail, opt_clr_end, opt_wrt_start, opt_wrt_mid;
  logic [15:0] opt_wval;

  always @(negedge clk) if (frm_err) frm_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse a strobe during the cycle in which the DUT acts on a pin edge driven at the last negedge
  task automatic strobe_in_act_cycle(input bit is_wrt, input logic [15:0] val);
    @(posedge clk);
    @(posedge clk);
    #1;
    if (is_wrt) begin wrt = 1'b1; tx_data = val; end
    else        clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    wrt     = 1'b0;
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_wrt(input logic [15:0] val);
    @(negedge clk);
    wrt = 1'b1; tx_data = val;
    @(negedge clk);
    wrt = 1'b0;
    model_tx_buf = val;
  endtask

  task automatic host_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  task automatic frame(input logic [15:0] mw, input int nr, input bit end_frame);
    bit full;
    full = (nr == 16) && end_frame;
    rd = '0;
    @(negedge clk);
    SS_n = 1'b0;
    if (opt_wrt_start) begin
      strobe_in_act_cycle(1'b1, opt_wval);
      model_tx_buf = opt_wval;
    end
    if (full) begin
      exp_cmd_q.push_back(mw);
      exp_miso_q.push_back(model_tx_buf);
    end
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nr; i++) begin
      SCLK = 1'b0;
      MOSI = mw[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      rd = {rd[14:0], miso_w};
      if (opt_wrt_mid && i == 7) begin
        wrt = 1'b1; tx_data = opt_wval;
        @(negedge clk);
        wrt = 1'b0;
        model_tx_buf = opt_wval;
      end
      repeat (HALF) @(negedge clk);
    end
    if (!end_frame) return;
    if (opt_trail && nr == 16) begin
      SCLK = 1'b0;
      if (opt_clr_end) strobe_in_act_cycle(1'b0, 16'h0);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SS_n = 1'b1;
    end else begin
      SS_n = 1'b1;
      if (opt_clr_end) strobe_in_act_cycle(1'b0, 16'h0);
    end
    repeat (6) @(negedge clk);
    if (full) begin
      check("cmd_rcvd", {16'h0, cmd_rcvd}, {16'h0, exp_cmd_q.pop_front()});
      check("miso_word", {16'h0, rd}, {16'h0, exp_miso_q.pop_front()});
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic clear_opts();
    opt_trail = 0; opt_clr_end = 0; opt_wrt_start = 0; opt_wrt_mid = 0; opt_wval = '0;
  endtask

  int fc0;

  initial begin
    clear_opts();
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; tx_data = '0; clr_rdy = 1'b0; model_tx_buf = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_miso_released", {31'h0, miso_w}, 32'h1);
    check("rst_rdy", {31'h0, rdy}, 32'h0);
    check("rst_ovr", {31'h0, ovr}, 32'h0);
    check("rst_frm_err", {31'h0, frm_err}, 32'h0);
    check("rst_cmd", {16'h0, cmd_rcvd}, 32'h0);

    // basic frame
    host_wrt(16'hA5C3);
    frame(16'h1234, 16, 1'b1);
    check("basic_rdy", {31'h0, rdy}, 32'h1);
    check("basic_ovr", {31'h0, ovr}, 32'h0);
    host_clr();
    check("basic_clr_rdy", {31'h0, rdy}, 32'h0);

    // overrun, second frame terminated by a trailing SCLK fall
    frame(16'h0F0F, 16, 1'b1);
    opt_trail = 1;
    frame(16'hF0F0, 16, 1'b1);
    clear_opts();
    check("ovr_rdy", {31'h0, rdy}, 32'h1);
    check("ovr_ovr", {31'h0, ovr}, 32'h1);
    host_clr();
    check("ovr_clr_ovr", {31'h0, ovr}, 32'h0);

    // clr_rdy in the completion cycle loses to completion
    frame(16'h0F0F, 16, 1'b1);
    opt_clr_end = 1;
    frame(16'hF0F0, 16, 1'b1);
    clear_opts();
    check("clr_coll_rdy", {31'h0, rdy}, 32'h1);
    check("clr_coll_ovr", {31'h0, ovr}, 32'h0);
    opt_trail = 1; opt_clr_end = 1;
    frame(16'h6A6A, 16, 1'b1);
    clear_opts();
    check("clr_coll_fall_rdy", {31'h0, rdy}, 32'h1);
    check("clr_coll_fall_ovr", {31'h0, ovr}, 32'h0);
    host_clr();

    // abort after 8 rises
    fc0 = frm_cnt;
    frame(16'hAAAA, 8, 1'b1);
    check("abort_frm_err_cycles", frm_cnt - fc0, 32'd1);
    check("abort_rdy", {31'h0, rdy}, 32'h0);
    check("abort_cmd", {16'h0, cmd_rcvd}, 32'h6A6A);
    frame(16'hBEEF, 16, 1'b1);
    check("after_abort_rdy", {31'h0, rdy}, 32'h1);
    host_clr();

    // response buffer timing
    opt_wrt_start = 1; opt_wval = 16'h5555;
    frame(16'h0001, 16, 1'b1);
    clear_opts();
    opt_wrt_mid = 1; opt_wval = 16'h3333;
    frame(16'h0002, 16, 1'b1);
    clear_opts();
    frame(16'h0003, 16, 1'b1);
    frame(16'h0004, 16, 1'b1);
    host_clr();

    // reset mid-frame after 5 rises
    frame(16'h1111, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", {31'h0, rdy}, 32'h0);
    check("midrst_ovr", {31'h0, ovr}, 32'h0);
    check("midrst_frm_err", {31'h0, frm_err}, 32'h0);
    check("midrst_cmd", {16'h0, cmd_rcvd}, 32'h0);
    check("midrst_miso_low", {31'h0, miso_w}, 32'h0);
    @(negedge clk);
    SS_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_miso_released", {31'h0, miso_w}, 32'h1);
    rst_n = 1'b1;
    model_tx_buf = '0;
    repeat (4) @(negedge clk);
    frame(16'h8001, 16, 1'b1);
    check("postrst_rdy", {31'h0, rdy}, 32'h1);

    check("queues_drained", exp_cmd_q.size() + exp_miso_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
